radix4_digit_reverse_buffer: RTL
================================

RADIX4_DIGIT_REVERSE_BUFFER -- requirements
Module: radix4_digit_reverse_buffer

Interface
REQ-001 The block SHALL have parameter LOG4N, default 3: log4 of the frame length (N = 4^LOG4N; 64 by default).
REQ-002 The block SHALL have parameter DW, default 32: width of each real and imaginary sample, signed two's complement.
REQ-003 The block SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid  input  1: an input sample is present.
REQ-006 The block SHALL have port in_re / in_im  input  DW each: the input sample, in digit-reversed order from the radix-4 SDF pipeline.
REQ-007 The block SHALL have port in_ready  output  1: the block can accept an input sample.
REQ-008 The block SHALL have port out_valid  output  1: out_re/out_im/out_last hold a valid sample.
REQ-009 The block SHALL have port out_ready  input  1: the downstream block accepts the output sample.
REQ-010 The block SHALL have port out_re / out_im  output  DW each: the output sample, in natural (bin) order.
REQ-011 The block SHALL have port out_last  output  1: the current output is bin N-1 of a frame.
REQ-012 The block SHALL have port ovf_err  output  1: sticky flag; set when in_valid is high while in_ready is low.

Function
REQ-013 Storage SHALL be two banks (ping-pong) of N complex words, each with a full flag; in_ready SHALL equal !full[wr_bank].
REQ-014 An input SHALL be accepted on a rising edge where in_valid && in_ready, written to bank wr_bank at address digitrev(wr_cnt), and wr_cnt SHALL then increment; digitrev reverses the order of the LOG4N base-4 digits.
REQ-015 On accepting wr_cnt == N-1: full[wr_bank] SHALL be set, wr_bank SHALL toggle, and wr_cnt SHALL wrap to 0.
REQ-016 A sample offered while in_ready is low SHALL be dropped (not written), and ovf_err SHALL be set.
REQ-017 The output register SHALL load mem[rd_bank][rd_cnt] on an edge where full[rd_bank] && (!out_valid || out_ready); on that edge out_valid SHALL be set, out_last SHALL be set to (rd_cnt == N-1), and rd_cnt SHALL increment.
REQ-018 On loading rd_cnt == N-1: full[rd_bank] SHALL clear, rd_bank SHALL toggle, and rd_cnt SHALL wrap to 0.
REQ-019 On an edge with out_valid && out_ready and no new load, out_valid SHALL clear; while out_valid && !out_ready, all output ports SHALL hold stable.
REQ-020 Latency: the first output of a frame SHALL be valid one cycle after the edge that accepts that frame's last input, provided the read side is idle.
REQ-021 Setting full on one bank and clearing full on the other SHALL both take effect on the same edge.
REQ-022 A bank freed at an edge SHALL show in_ready high in the following cycle.
REQ-023 With out_ready held high, the block SHALL sustain one sample per cycle in and out indefinitely with no in_ready deassertion.
REQ-024 Sample data SHALL pass through bit-exact; no arithmetic SHALL be applied except as set out in REQ-028.

Reset
REQ-025 While rst_n is low: wr_cnt, rd_cnt, wr_bank and rd_bank SHALL be 0; both full flags SHALL be 0; out_valid, out_last and ovf_err SHALL be 0; out_re and out_im SHALL be 0; in_ready SHALL be 1.
REQ-026 Reset asserted mid-frame SHALL discard all partial and complete frames; bank memory contents need not be cleared.

Configuration
REQ-027 The macro R4_REORDER_CONJ_EN SHALL select output conjugation.
REQ-028 With R4_REORDER_CONJ_EN defined, out_im SHALL be the negated stored imaginary part, with -2^(DW-1) saturating to 2^(DW-1)-1 (this supports IFFT via the conjugate method); out_re SHALL be unchanged.
REQ-029 Without R4_REORDER_CONJ_EN, out_im SHALL equal the stored value.

Verification (LOG4N=2, N=16)
REQ-030 Scenario: feed in_re = k, in_im = -k for k = 0..15 on consecutive cycles, out_ready=1 -> outputs out_re in order 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; out_last high only on 15; first out_valid one cycle after the 16th input.
REQ-031 Scenario: stream 4 back-to-back frames with out_ready=1 -> in_ready never low, 64 outputs with no gaps, out_last every 16th output.
REQ-032 Scenario: out_ready=0, then two frames fed -> in_ready low after the 32nd input; a 33rd in_valid sets ovf_err=1; then out_ready=1 -> 32 correct outputs, and in_ready high the cycle after bank 0 drains.
REQ-033 Scenario: out_ready toggled 1,0,1,0 during drain -> out_re stable while stalled, no sample lost or duplicated.
REQ-034 Scenario: rst_n pulsed low after 7 inputs -> all outputs take their reset values; a fresh 16-sample frame then reorders correctly.
REQ-035 Scenario: with R4_REORDER_CONJ_EN defined, feed in_im = 5 and in_im = -2^31 -> outputs -5 and 2^31-1.

Source files
------------

// File: rtl/radix4_digit_reverse_buffer.sv
// Ping-pong reorder buffer: radix-4 digit-reversed input order to natural bin order.
// Define R4_REORDER_CONJ_EN to conjugate outputs (saturating negate of the imaginary part).
module radix4_digit_reverse_buffer #(
   parameter int LOG4N = 3,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] in_re,
   input  logic [DW-1:0] in_im,
   output logic          in_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_re,
   output logic [DW-1:0] out_im,
   output logic          out_last,
   output logic          ovf_err
);
   localparam int AW = 2 * LOG4N;
   localparam int N  = 1 << AW;
   localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
   localparam logic [DW-1:0] MIN_VAL   = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0] MAX_VAL   = {1'b0, {(DW-1){1'b1}}};

   logic [DW-1:0] r_mem_re [2][N];
   logic [DW-1:0] r_mem_im [2][N];

   logic [AW-1:0] r_wr_cnt, r_rd_cnt;
   logic          r_wr_bank, r_rd_bank;
   logic [1:0]    r_full;
   logic          r_out_valid, r_out_last, r_ovf_err;
   logic [DW-1:0] r_out_re, r_out_im;

   logic          w_wr_en, w_wr_last, w_ld, w_rd_last;
   logic [1:0]    w_full_nxt;
   logic [DW-1:0] w_rd_re, w_rd_im, w_mem_im;

   // Reverse the order of the base-4 digits of the write counter.
   function automatic logic [AW-1:0] digitrev(input logic [AW-1:0] a);
      logic [AW-1:0] r;
      r = '0;
      for (int i = 0; i < LOG4N; i++) r[2*i +: 2] = a[2*(LOG4N-1-i) +: 2];
      return r;
   endfunction

   assign in_ready  = !r_full[r_wr_bank];
   assign w_wr_en   = in_valid && in_ready;
   assign w_wr_last = (r_wr_cnt == LAST_ADDR);
   assign w_ld      = r_full[r_rd_bank] && (!r_out_valid || out_ready);
   assign w_rd_last = (r_rd_cnt == LAST_ADDR);

   assign w_rd_re  = r_mem_re[r_rd_bank][r_rd_cnt];
   assign w_mem_im = r_mem_im[r_rd_bank][r_rd_cnt];
`ifdef R4_REORDER_CONJ_EN
   assign w_rd_im  = (w_mem_im == MIN_VAL) ? MAX_VAL : -w_mem_im;
`else
   assign w_rd_im  = w_mem_im;
`endif

   // A bank can be filled and the other drained on the same edge; they never collide.
   always_comb begin
      w_full_nxt = r_full;
      if (w_wr_en && w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
      if (w_ld && w_rd_last)    w_full_nxt[r_rd_bank] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem_re[r_wr_bank][digitrev(r_wr_cnt)] <= in_re;
         r_mem_im[r_wr_bank][digitrev(r_wr_cnt)] <= in_im;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_cnt    <= '0;
         r_rd_cnt    <= '0;
         r_wr_bank   <= 1'b0;
         r_rd_bank   <= 1'b0;
         r_full      <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_re    <= '0;
         r_out_im    <= '0;
         r_ovf_err   <= 1'b0;
      end else begin
         r_full <= w_full_nxt;
         if (in_valid && !in_ready) r_ovf_err <= 1'b1;
         if (w_wr_en) begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
            if (w_wr_last) r_wr_bank <= !r_wr_bank;
         end
         if (w_ld) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_rd_last;
            r_out_re    <= w_rd_re;
            r_out_im    <= w_rd_im;
            r_rd_cnt    <= r_rd_cnt + 1'b1;
            if (w_rd_last) r_rd_bank <= !r_rd_bank;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign out_re    = r_out_re;
   assign out_im    = r_out_im;
   assign ovf_err   = r_ovf_err;

endmodule
